// File: rtl/alarm_ctrl.sv
// Alarm controller: detects the rising edge of a time/alarm match and then
// sequences RING and SNOOZE periods counted in 1 Hz ticks, with debounced
// (synchronized, edge-detected) snooze and stop buttons.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] th1,
    input  logic [3:0] th0,
    input  logic [3:0] tm1,
    input  logic [3:0] tm0,
    input  logic [3:0] ah1,
    input  logic [3:0] ah0,
    input  logic [3:0] am1,
    input  logic [3:0] am0,
    input  logic       alarm_en,
    input  logic       snooze_n,
    input  logic       stop_n,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer,
    output logic [8:0] remaining,
    output logic [2:0] snooze_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    localparam logic [8:0] RING_LOAD   = 9'(RING_SEC);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC);
    localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);

    state_t     state, state_nx;
    logic [8:0] remaining_nx;
    logic [2:0] snooze_cnt_nx;
    logic       beep, beep_nx;

    logic sn_s1, sn_s2, sn_h;
    logic st_s1, st_s2, st_h;
    logic snooze_press, stop_press;
    logic match, match_q, match_rise;

    // Two-flop synchronizers plus history flops; idle level is 1 (released).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sn_s1 <= 1'b1; sn_s2 <= 1'b1; sn_h <= 1'b1;
            st_s1 <= 1'b1; st_s2 <= 1'b1; st_h <= 1'b1;
        end else begin
            sn_s1 <= snooze_n; sn_s2 <= sn_s1; sn_h <= sn_s2;
            st_s1 <= stop_n;   st_s2 <= st_s1; st_h <= st_s2;
        end
    end

    // A press is the 1->0 edge between history and second stage: one pulse per hold.
    assign snooze_press = sn_h & ~sn_s2;
    assign stop_press   = st_h & ~st_s2;

    assign match      = ({th1, th0, tm1, tm0} == {ah1, ah0, am1, am0});
    assign match_rise = match & ~match_q;

    // Register the match so only its rising edge can trigger an alarm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_q <= 1'b0;
        else       match_q <= match;
    end

    // State register together with the counters that move with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            remaining  <= 9'd0;
            beep       <= 1'b0;
            snooze_cnt <= 3'd0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            beep       <= beep_nx;
            snooze_cnt <= snooze_cnt_nx;
        end
    end

    // Next-state: alarm_en low beats stop, stop beats snooze, snooze beats tick.
    always_comb begin
        state_nx      = state;
        remaining_nx  = remaining;
        beep_nx       = beep;
        snooze_cnt_nx = snooze_cnt;
        if (!alarm_en) begin
            state_nx     = S_IDLE;
            remaining_nx = 9'd0;
            beep_nx      = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (match_rise) begin
                        state_nx      = S_RING;
                        remaining_nx  = RING_LOAD;
                        beep_nx       = 1'b1;
                        snooze_cnt_nx = 3'd0;
                    end
                end
                S_RING: begin
                    if (stop_press) begin
                        state_nx     = S_IDLE;
                        remaining_nx = 9'd0;
                        beep_nx      = 1'b0;
                    end else if (snooze_press && (snooze_cnt < MAX_CNT)) begin
                        state_nx      = S_SNOOZE;
                        remaining_nx  = SNOOZE_LOAD;
                        snooze_cnt_nx = snooze_cnt + 3'd1;
                    end else if (tick) begin
                        // A snooze press at the limit is ignored, so the tick still counts.
                        if (remaining <= 9'd1) begin
                            state_nx     = S_IDLE;
                            remaining_nx = 9'd0;
                            beep_nx      = 1'b0;
                        end else begin
                            remaining_nx = remaining - 9'd1;
                            beep_nx      = ~beep;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (stop_press) begin
                        state_nx     = S_IDLE;
                        remaining_nx = 9'd0;
                        beep_nx      = 1'b0;
                    end else if (tick) begin
                        if (remaining <= 9'd1) begin
                            state_nx     = S_RING;
                            remaining_nx = RING_LOAD;
                            beep_nx      = 1'b1;
                        end else begin
                            remaining_nx = remaining - 9'd1;
                        end
                    end
                end
                default: begin
                    state_nx     = S_IDLE;
                    remaining_nx = 9'd0;
                    beep_nx      = 1'b0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    always_comb begin
        ringing   = (state == S_RING);
        snoozing  = (state == S_SNOOZE);
        buzzer    = (state == S_RING) && beep;
        state_dbg = state;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60: ring duration, in ticks (1..511).
REQ-002 Parameter SNOOZE_SEC, default 300: snooze duration, in ticks (1..511).
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event (0..7).
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 tick  in  1  1 Hz strobe, one clk cycle high per second, synchronous to clk.
REQ-007 th1, th0, tm1, tm0  in  4 each  running time, BCD, 24 h format.
REQ-008 ah1, ah0, am1, am0  in  4 each  alarm setting, BCD, from the alarm-set block.
REQ-009 alarm_en  in  1  alarm enable switch, level, synchronous to clk.
REQ-010 snooze_n  in  1  snooze push button, active-low, asynchronous.
REQ-011 stop_n  in  1  stop push button, active-low, asynchronous.
REQ-012 ringing  out  1  high in RING.
REQ-013 snoozing  out  1  high in SNOOZE.
REQ-014 buzzer  out  1  audible drive; ringing AND beep phase.
REQ-015 remaining  out  9  ticks left in current RING/SNOOZE; 0 in IDLE.
REQ-016 snooze_cnt  out  3  snoozes taken in current alarm event.

Function
REQ-017 snooze_n and stop_n shall each pass through a 2-flop synchronizer plus a history flop; a press is a 1-to-0 transition between history and second stage, giving a one-clk pulse.
REQ-018 A press shall take effect at the 3rd rising clk edge after the pin falls, given setup is met; a held button shall produce one pulse only.
REQ-019 match = all four time digits equal all four alarm digits; match shall be registered each clk, and match_rise = match AND NOT match_q.
REQ-020 FSM states: IDLE, RING, SNOOZE; encoding is free.
REQ-021 IDLE -> RING on match_rise AND alarm_en; load remaining=RING_SEC, beep=1, snooze_cnt=0.
REQ-022 RING, stop pulse -> IDLE.
REQ-023 RING, snooze pulse with snooze_cnt<MAX_SNOOZE -> SNOOZE; load remaining=SNOOZE_SEC; snooze_cnt+1.
REQ-024 RING, snooze pulse with snooze_cnt==MAX_SNOOZE: ignored; stay in RING; counters unchanged.
REQ-025 RING, tick: remaining-1, beep toggles; tick with remaining==1 -> IDLE.
REQ-026 SNOOZE, stop pulse -> IDLE; snooze pulse ignored.
REQ-027 SNOOZE, tick: remaining-1; tick with remaining==1 -> RING; load remaining=RING_SEC, beep=1.
REQ-028 alarm_en low in any state -> IDLE at next edge; takes priority over all other events.
REQ-029 Priority within one cycle: alarm_en low > stop > snooze > tick; a tick in the same cycle as an accepted button press is not counted.
REQ-030 match_rise in RING or SNOOZE shall be ignored; match staying high after a return to IDLE shall not re-trigger.
REQ-031 On entering IDLE: remaining=0, beep=0; snooze_cnt holds its value until the next trigger.
REQ-032 remaining shall never wrap below 0 or exceed the loaded parameter.
REQ-033 Changing the alarm digits to equal the current time while in IDLE with alarm_en high shall trigger the alarm (match_rise).

Reset
REQ-034 Reset asserted shall immediately force: state IDLE, ringing=0, snoozing=0, buzzer=0, remaining=0, snooze_cnt=0, beep=0, match_q=0, synchronizer and history flops=1.
REQ-035 Reset mid-RING or mid-SNOOZE shall abort without a buzzer glitch; after release, a match already present shall trigger at the first clk edge.

Verification
REQ-036 Alarm 07:30, time steps 07:29->07:30, alarm_en=1 -> ringing=1, remaining=60, buzzer=1 one clk later; buzzer toggles per tick.
REQ-037 RING, 60 ticks with no press -> IDLE after the 60th tick; remaining=0; no re-trigger while time stays 07:30.
REQ-038 RING, snooze press -> snoozing=1, remaining=300, snooze_cnt=1; after 300 ticks, ringing=1, remaining=60.
REQ-039 Three snooze cycles then a 4th snooze press -> stays in RING, snooze_cnt=3; stop press -> IDLE.
REQ-040 snooze and stop fall in the same cycle during RING -> IDLE (stop wins); tick in the same cycle is not counted.
REQ-041 alarm_en dropped mid-SNOOZE -> IDLE next edge; reset pulse mid-RING -> all outputs 0 asynchronously.
